// File: rtl/pwm_freq_pkg.sv
// Shared constants for the PWM frequency selector: frequency table, blank
// digit code, double-dabble state encoding and the table range check.
package pwm_freq_pkg;

    localparam int N_FREQ = 8;
    localparam int FREQ_TABLE [N_FREQ] = '{25, 50, 100, 200, 500, 1000, 2000, 5000};

    localparam logic [3:0] BCD_BLANK = 4'd10;

    typedef enum logic [1:0] {
        DD_IDLE,
        DD_LOAD,
        DD_SHIFT,
        DD_DONE
    } dd_state_e;

    // True when the first n_sel entries exist and fit both the binary width
    // and the number of decimal digits shown.
    function automatic bit table_fits(input int n_sel, input int val_w, input int digits);
        int lim;
        bit ok;
        lim = 1;
        ok  = (n_sel <= N_FREQ) && (n_sel >= 2);
        for (int d = 0; d < digits; d++) lim = lim * 10;
        for (int i = 0; i < N_FREQ; i++) begin
            if (i < n_sel && (FREQ_TABLE[i] >= lim || FREQ_TABLE[i] >= (1 << val_w)))
                ok = 1'b0;
        end
        return ok;
    endfunction

endpackage

// File: rtl/bcd_dd_seq.sv
// Sequential double-dabble binary-to-BCD converter: one bit per cycle,
// start/busy/done handshake, result held until the next conversion.
module bcd_dd_seq
    import pwm_freq_pkg::*;
#(
    parameter int VAL_W  = 14,
    parameter int DIGITS = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_start,
    input  logic [VAL_W-1:0]      i_bin,
    output logic                  o_busy,
    output logic                  o_load,
    output logic                  o_done,
    output logic [4*DIGITS-1:0]   o_bcd
);

    localparam int CNT_W = $clog2(VAL_W + 1);

    dd_state_e             r_state;
    logic [VAL_W-1:0]      r_bin;
    logic [4*DIGITS-1:0]   r_bcd;
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_busy;
    logic [4*DIGITS-1:0]   w_adj;

    always_comb begin
        w_adj = r_bcd;
        for (int i = 0; i < DIGITS; i++) begin
            if (r_bcd[4*i +: 4] >= 4'd5) w_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= DD_IDLE;
            r_bin   <= '0;
            r_bcd   <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                DD_IDLE: begin
                    if (i_start) begin
                        r_state <= DD_LOAD;
                        r_busy  <= 1'b1;
                    end
                end
                DD_LOAD: begin
                    r_bin   <= i_bin;
                    r_bcd   <= '0;
                    r_cnt   <= '0;
                    r_state <= DD_SHIFT;
                end
                DD_SHIFT: begin
                    // Corrected digits and remaining binary bits shift as one word.
                    {r_bcd, r_bin} <= {w_adj[4*DIGITS-2:0], r_bin, 1'b0};
                    r_cnt          <= r_cnt + 1'b1;
                    if (r_cnt == CNT_W'(VAL_W - 1)) r_state <= DD_DONE;
                end
                DD_DONE: begin
                    r_state <= DD_IDLE;
                    r_busy  <= 1'b0;
                end
                default: r_state <= DD_IDLE;
            endcase
        end
    end

    assign o_busy = r_busy;
    assign o_load = (r_state == DD_LOAD);
    assign o_done = (r_state == DD_DONE);
    assign o_bcd  = r_bcd;

endmodule

// File: rtl/pwm_freq_sel.sv
// PWM frequency selector: button-stepped index, table lookup, BCD display
// conversion and period-boundary hand-over of the index to the PWM datapath.
module pwm_freq_sel
    import pwm_freq_pkg::*;
#(
    parameter int N_SEL    = 8,
    parameter int SEL_W    = $clog2(N_SEL),
    parameter int VAL_W    = 14,
    parameter int DIGITS   = 4,
    parameter bit WRAP     = 1'b1,
    parameter bit LZ_BLANK = 1'b1
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_btn_up,
    input  logic                  i_btn_dn,
    input  logic                  i_period_end,
    output logic [SEL_W-1:0]      o_sel,
    output logic [SEL_W-1:0]      o_sel_applied,
    output logic                  o_period_load,
    output logic [VAL_W-1:0]      o_freq_hz,
    output logic [4*DIGITS-1:0]   o_bcd,
    output logic                  o_bcd_valid,
    output logic                  o_busy
);

    if (!table_fits(N_SEL, VAL_W, DIGITS)) begin : g_range_err
        $error("pwm_freq_sel: FREQ_TABLE entry exceeds VAL_W or DIGITS range");
    end

    localparam logic [SEL_W-1:0] SEL_MAX = SEL_W'(N_SEL - 1);

    logic [SEL_W-1:0]      r_sel, r_sel_app;
    logic                  r_period_load, r_bcd_valid, r_pending;
    logic [4*DIGITS-1:0]   r_bcd;

    logic [SEL_W-1:0]      w_sel_nxt;
    logic                  w_change, w_start, w_load, w_done, w_busy;
    logic [4*DIGITS-1:0]   w_bcd_raw;

    function automatic logic [4*DIGITS-1:0] blank_lz(input logic [4*DIGITS-1:0] d);
        logic lead;
        blank_lz = d;
        lead     = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            if (lead && d[4*i +: 4] == 4'd0) blank_lz[4*i +: 4] = BCD_BLANK;
            else lead = 1'b0;
        end
    endfunction

    always_comb begin
        w_sel_nxt = r_sel;
        if (i_btn_up && !i_btn_dn) begin
            if (r_sel != SEL_MAX) w_sel_nxt = r_sel + 1'b1;
            else if (WRAP)        w_sel_nxt = '0;
        end else if (i_btn_dn && !i_btn_up) begin
            if (r_sel != '0) w_sel_nxt = r_sel - 1'b1;
            else if (WRAP)   w_sel_nxt = SEL_MAX;
        end
    end

    // A same-cycle change starts the engine directly so LOAD sees the new index.
    assign w_change  = (w_sel_nxt != r_sel);
    assign w_start   = r_pending | w_change;
    assign o_freq_hz = VAL_W'(FREQ_TABLE[r_sel]);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_sel         <= '0;
            r_sel_app     <= '0;
            r_period_load <= 1'b0;
            r_bcd         <= '0;
            r_bcd_valid   <= 1'b0;
            r_pending     <= 1'b1;
        end else begin
            r_sel <= w_sel_nxt;
            if (w_change)    r_pending <= 1'b1;
            else if (w_load) r_pending <= 1'b0;
            if (w_change)    r_bcd_valid <= 1'b0;
            else if (w_done) r_bcd_valid <= !r_pending;
            if (w_done) r_bcd <= LZ_BLANK ? blank_lz(w_bcd_raw) : w_bcd_raw;
            r_period_load <= i_period_end && (r_sel != r_sel_app);
            if (i_period_end && (r_sel != r_sel_app)) r_sel_app <= r_sel;
        end
    end

    bcd_dd_seq #(
        .VAL_W  (VAL_W),
        .DIGITS (DIGITS)
    ) u_dd (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_start (w_start),
        .i_bin   (o_freq_hz),
        .o_busy  (w_busy),
        .o_load  (w_load),
        .o_done  (w_done),
        .o_bcd   (w_bcd_raw)
    );

    assign o_sel         = r_sel;
    assign o_sel_applied = r_sel_app;
    assign o_period_load = r_period_load;
    assign o_bcd         = r_bcd;
    assign o_bcd_valid   = r_bcd_valid;
    assign o_busy        = w_busy;

endmodule

// File: tb/tb_pwm_freq_sel.sv
// Bench for pwm_freq_sel: a wrapping/blanking instance and a saturating/
// unblanked instance driven together against a decimal-arithmetic model.
module tb_pwm_freq_sel;

    localparam int N  = 8;
    localparam int SW = 3;
    localparam int VW = 14;
    localparam int DG = 4;
    localparam int TBL [N] = '{25, 50, 100, 200, 500, 1000, 2000, 5000};

    logic clk = 1'b0, rst_n = 1'b0, up = 1'b0, dn = 1'b0, pe = 1'b0;
    logic [SW-1:0] sel_a, app_a, sel_b, app_b;
    logic          pl_a, pl_b, vld_a, vld_b, busy_a, busy_b;
    logic [VW-1:0] hz_a, hz_b;
    logic [15:0]   bcd_a, bcd_b;

    int n_chk = 0, n_err = 0;
    int m_sel [2];
    int m_app [2];
    bit m_pl  [2];

    always #5 clk = ~clk;

    pwm_freq_sel u_dut_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_btn_up(up), .i_btn_dn(dn), .i_period_end(pe),
        .o_sel(sel_a), .o_sel_applied(app_a), .o_period_load(pl_a), .o_freq_hz(hz_a),
        .o_bcd(bcd_a), .o_bcd_valid(vld_a), .o_busy(busy_a)
    );

    pwm_freq_sel #(.WRAP(1'b0), .LZ_BLANK(1'b0)) u_dut_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_btn_up(up), .i_btn_dn(dn), .i_period_end(pe),
        .o_sel(sel_b), .o_sel_applied(app_b), .o_period_load(pl_b), .o_freq_hz(hz_b),
        .o_bcd(bcd_b), .o_bcd_valid(vld_b), .o_busy(busy_b)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Decimal digits of v, one nibble each; leading zeros above the units blanked.
    function automatic int exp_bcd(input int v, input bit blank);
        int r, p, d;
        r = 0;
        p = 1;
        for (int i = 0; i < DG; i++) begin
            d = (v / p) % 10;
            if (blank && i > 0 && v < p) d = 10;
            r = r | (d << (4 * i));
            p = p * 10;
        end
        return r;
    endfunction

    function automatic int nxt(input int s, input bit u, input bit d, input bit wrap);
        if (u && !d) return (s == N - 1) ? (wrap ? 0 : s) : s + 1;
        if (d && !u) return (s == 0) ? (wrap ? N - 1 : s) : s - 1;
        return s;
    endfunction

    task automatic step(input bit u, input bit d, input bit p);
        bit chg [2];
        int ns;
        up = u; dn = d; pe = p;
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            chg[k] = 1'b0;
            if (!rst_n) begin
                m_sel[k] = 0; m_app[k] = 0; m_pl[k] = 1'b0;
            end else begin
                m_pl[k] = p && (m_sel[k] != m_app[k]);
                if (m_pl[k]) m_app[k] = m_sel[k];
                ns       = nxt(m_sel[k], u, d, k == 0);
                chg[k]   = (ns != m_sel[k]);
                m_sel[k] = ns;
            end
        end
        #1;
        up = 1'b0; dn = 1'b0; pe = 1'b0;
        chk("sel_a", sel_a, m_sel[0]);
        chk("sel_b", sel_b, m_sel[1]);
        chk("app_a", app_a, m_app[0]);
        chk("app_b", app_b, m_app[1]);
        chk("pl_a", pl_a, m_pl[0]);
        chk("pl_b", pl_b, m_pl[1]);
        chk("hz_a", hz_a, TBL[m_sel[0]]);
        chk("hz_b", hz_b, TBL[m_sel[1]]);
        if (vld_a) chk("bcd_a", bcd_a, exp_bcd(TBL[m_sel[0]], 1'b1));
        if (vld_b) chk("bcd_b", bcd_b, exp_bcd(TBL[m_sel[1]], 1'b0));
        if (chg[0]) chk("vld_clr_a", vld_a, 0);
        if (chg[1]) chk("vld_clr_b", vld_b, 0);
        if (!rst_n) begin
            chk("rst_bcd_a", bcd_a, 0);
            chk("rst_bcd_b", bcd_b, 0);
            chk("rst_vld_a", vld_a, 0);
            chk("rst_vld_b", vld_b, 0);
            chk("rst_busy_a", busy_a, 0);
            chk("rst_busy_b", busy_b, 0);
        end
    endtask

    task automatic settle(input int max);
        int cyc;
        cyc = 0;
        while (!(vld_a && vld_b) && cyc < max) begin
            step(1'b0, 1'b0, 1'b0);
            cyc++;
        end
        chk("settle_vld", {30'd0, vld_a, vld_b}, 3);
        chk("settle_busy", {30'd0, busy_a, busy_b}, 0);
        chk("settle_bcd_a", bcd_a, exp_bcd(TBL[m_sel[0]], 1'b1));
        chk("settle_bcd_b", bcd_b, exp_bcd(TBL[m_sel[1]], 1'b0));
    endtask

    task automatic lat_to_vld(input int max, input int press_at, output int lat, output int nbusy);
        lat   = 0;
        nbusy = 0;
        while (!vld_a && lat < max) begin
            step(lat == press_at, 1'b0, 1'b0);
            lat++;
            nbusy += int'(busy_a);
        end
    endtask

    initial begin
        int lat, nb;
        for (int k = 0; k < 2; k++) begin m_sel[k] = 0; m_app[k] = 0; m_pl[k] = 1'b0; end

        rst_n = 1'b0;
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;

        // First conversion after reset: 17 cycles, busy for LOAD..DONE.
        lat_to_vld(40, -1, lat, nb);
        chk("lat_rst", lat, 17);
        chk("busy_cycles", nb, 16);
        chk("bcd_rst_a", bcd_a, 32'hAA25);
        chk("bcd_rst_b", bcd_b, 32'h0025);
        chk("app_rst", app_a, 0);

        repeat (5) begin step(1'b1, 1'b0, 1'b0); step(1'b0, 1'b0, 1'b0); end
        settle(80);
        chk("up5_sel", sel_a, 5);
        chk("up5_hz", hz_a, 1000);
        chk("up5_bcd", bcd_a, 32'h1000);
        chk("up5_app_hold", app_a, 0);
        step(1'b0, 1'b0, 1'b1);
        chk("up5_app", app_a, 5);
        chk("up5_pl", pl_a, 1);
        step(1'b0, 1'b0, 1'b0);
        chk("up5_pl_end", pl_a, 0);

        // Single press from idle: result 16 cycles after the press cycle.
        step(1'b1, 1'b0, 1'b0);
        lat_to_vld(40, -1, lat, nb);
        chk("lat_press", lat, 16);
        chk("bcd_2000", bcd_a, 32'h2000);

        // Press three cycles into a conversion forces a restart.
        step(1'b1, 1'b0, 1'b0);
        lat_to_vld(80, 2, lat, nb);
        chk("lat_restart", lat, 33);
        chk("bcd_restart", bcd_a, 32'hAA25);
        settle(80);
        chk("sat_sel_b", sel_b, 7);
        step(1'b1, 1'b0, 1'b0);
        chk("sat_hold_b", sel_b, 7);
        chk("sat_vld_b", vld_b, 1);
        chk("sat_busy_b", busy_b, 0);
        step(1'b0, 1'b0, 1'b0);
        chk("sat_busy_b2", busy_b, 0);

        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        settle(80);
        chk("wrap_sel_a", sel_a, 7);
        chk("wrap_bcd_a", bcd_a, 32'h5000);

        // Button coinciding with period_end is applied one period later.
        step(1'b0, 1'b0, 1'b1);
        chk("pe_app_7", app_a, 7);
        step(1'b1, 1'b0, 1'b1);
        chk("pe_same_app", app_a, 7);
        chk("pe_same_pl", pl_a, 0);
        step(1'b0, 1'b0, 1'b1);
        chk("pe_next_app", app_a, 0);
        chk("pe_next_pl", pl_a, 1);
        step(1'b1, 1'b1, 1'b0);
        chk("both_btn", sel_a, 0);
        settle(80);

        // Reset in the middle of SHIFT.
        step(1'b1, 1'b0, 1'b0);
        repeat (5) step(1'b0, 1'b0, 1'b0);
        chk("mid_busy", busy_a, 1);
        rst_n = 1'b0;
        step(1'b0, 1'b0, 1'b0);
        chk("mid_rst_sel", sel_a, 0);
        rst_n = 1'b1;
        lat_to_vld(40, -1, lat, nb);
        chk("lat_mid_rst", lat, 17);
        chk("bcd_mid_rst", bcd_a, 32'hAA25);

        repeat (1500) begin
            if ($urandom_range(0, 399) == 0) rst_n = 1'b0;
            step($urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0, $urandom_range(0, 4) == 0);
            rst_n = 1'b1;
        end
        settle(80);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
